// File: rtl/bomb_game_sequencer.sv
// Game-flow sequencer for the bomb puzzle: arming delay, countdown,
// detonation delay and win/lose end states, all timed off one prescaler.
module bomb_game_sequencer #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int ARM_SECONDS   = 3,
  parameter int DET_SECONDS   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic [1:0] time_limit_sel,
  input  logic       explode,
  input  logic       all_solved,
  output logic [2:0] current_state,
  output logic [8:0] time_left_sec,
  output logic       time_out,
  output logic       sec_tick
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SEC_MAX = (ARM_SECONDS > DET_SECONDS) ? ARM_SECONDS : DET_SECONDS;
  localparam int SW = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;
  localparam logic [PW-1:0] P_TERM = PW'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0] ARM_LAST = SW'(ARM_SECONDS - 1);
  localparam logic [SW-1:0] DET_LAST = SW'(DET_SECONDS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'b000,
    S_ACTIVATING = 3'b001,
    S_ACTIVATED  = 3'b010,
    S_DETONATING = 3'b011,
    S_FAILED     = 3'b100,
    S_SUCCESS    = 3'b101
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_presc;
  logic [SW-1:0]   r_psec;
  logic [1:0]      r_sel;
  logic [8:0]      r_left;
  logic            r_tout;
  logic            r_tick;
  logic            w_term;

  assign w_term = (r_presc == P_TERM);

  function automatic logic [8:0] limit_secs(input logic [1:0] s);
    case (s)
      2'b00:   limit_secs = 9'd300;
      2'b01:   limit_secs = 9'd180;
      2'b10:   limit_secs = 9'd120;
      default: limit_secs = 9'd60;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_psec  <= '0;
      r_sel   <= 2'b00;
      r_left  <= 9'd0;
      r_tout  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_tick  <= 1'b0;
      r_presc <= w_term ? '0 : r_presc + PW'(1);
      case (r_state)
        S_IDLE: begin
          r_left <= 9'd0;
          r_tout <= 1'b0;
          if (start_btn) begin
            r_state <= S_ACTIVATING;
            r_sel   <= time_limit_sel;
            r_presc <= '0;
            r_psec  <= '0;
          end
        end
        S_ACTIVATING: begin
          if (w_term) begin
            if (r_psec == ARM_LAST) begin
              r_state <= S_ACTIVATED;
              r_left  <= limit_secs(r_sel);
              r_psec  <= '0;
            end else begin
              r_psec <= r_psec + SW'(1);
            end
          end
        end
        S_ACTIVATED: begin
          if (explode || r_tout) begin
            r_state <= S_DETONATING;
            r_presc <= '0;
            r_psec  <= '0;
          end else if (all_solved) begin
            r_state <= S_SUCCESS;
            r_presc <= '0;
          end else if (w_term && r_left != 9'd0) begin
            // Expiry is flagged on the same edge the count reaches zero
            r_left <= r_left - 9'd1;
            r_tick <= 1'b1;
            if (r_left == 9'd1) r_tout <= 1'b1;
          end
        end
        S_DETONATING: begin
          if (w_term) begin
            if (r_psec == DET_LAST) begin
              r_state <= S_FAILED;
              r_psec  <= '0;
            end else begin
              r_psec <= r_psec + SW'(1);
            end
          end
        end
        S_FAILED, S_SUCCESS: begin
          if (start_btn) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_left  <= 9'd0;
            r_tout  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_presc <= '0;
        end
      endcase
    end
  end

  assign current_state = r_state;
  assign time_left_sec = r_left;
  assign time_out      = r_tout;
  assign sec_tick      = r_tick;

endmodule

// File: tb/tb_bomb_game_sequencer.sv
// Scoreboard bench for bomb_game_sequencer: a cycle-level game model
// predicts outputs; a monitor compares them after every clock edge.
module tb_bomb_game_sequencer;

  localparam int T   = 4;
  localparam int ARM = 2;
  localparam int DET = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn;
  logic [1:0] time_limit_sel;
  logic       explode;
  logic       all_solved;
  logic [2:0] current_state;
  logic [8:0] time_left_sec;
  logic       time_out;
  logic       sec_tick;

  always #5 clk = ~clk;

  bomb_game_sequencer #(
    .TICKS_PER_SEC(T),
    .ARM_SECONDS(ARM),
    .DET_SECONDS(DET)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_btn(start_btn),
    .time_limit_sel(time_limit_sel),
    .explode(explode),
    .all_solved(all_solved),
    .current_state(current_state),
    .time_left_sec(time_left_sec),
    .time_out(time_out),
    .sec_tick(sec_tick)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [8:0] left;
    logic       tout;
    logic       tick;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  logic rst_v;

  // game model: phase, cycles spent in phase, seconds left
  int m_st, m_cyc, m_limit, m_left;
  bit m_tout, m_tick;

  task automatic check(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, want, $time);
    end
  endtask

  function automatic int secs(input logic [1:0] s);
    case (s)
      2'd0:    return 300;
      2'd1:    return 180;
      2'd2:    return 120;
      default: return 60;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic s, input logic [1:0] sel,
                            input logic ex, input logic so);
    m_tick = 0;
    if (!r) begin
      m_st = 0; m_cyc = 0; m_left = 0; m_tout = 0; m_limit = 300;
    end else begin
      case (m_st)
        0: if (s) begin m_st = 1; m_cyc = 0; m_limit = secs(sel); end
        1: begin
          m_cyc++;
          if (m_cyc == ARM * T) begin m_st = 2; m_cyc = 0; m_left = m_limit; end
        end
        2: begin
          if (ex || m_tout) begin m_st = 3; m_cyc = 0; end
          else if (so) m_st = 5;
          else begin
            m_cyc++;
            if (m_cyc % T == 0 && m_left > 0) begin
              m_left--; m_tick = 1;
              if (m_left == 0) m_tout = 1;
            end
          end
        end
        3: begin
          m_cyc++;
          if (m_cyc == DET * T) m_st = 4;
        end
        default: if (s) begin m_st = 0; m_left = 0; m_tout = 0; end
      endcase
    end
  endtask

  task automatic cyc(input logic s, input logic [1:0] sel, input logic ex, input logic so);
    exp_t e;
    @(negedge clk);
    rst = rst_v; start_btn = s; time_limit_sel = sel; explode = ex; all_solved = so;
    model_step(rst_v, s, sel, ex, so);
    e.st = 3'(m_st); e.left = 9'(m_left); e.tout = m_tout; e.tick = m_tick;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("state", current_state, e.st);
        check("time_left", time_left_sec, e.left);
        check("time_out", time_out, e.tout);
        check("sec_tick", sec_tick, e.tick);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rst_v = 1'b0;
    start_btn = 0; time_limit_sel = 0; explode = 0; all_solved = 0;
    repeat (3) cyc(0, 0, 0, 0);
    #1;
    check("rst_state", current_state, 0);
    check("rst_left", time_left_sec, 0);
    rst_v = 1'b1;

    // start with 60 s; noise while arming must be ignored
    cyc(1, 2'b11, 0, 0);
    cyc(0, 2'b00, 1, 0);
    cyc(0, 2'b01, 0, 1);
    cyc(1, 2'b10, 0, 0);
    cyc(0, 2'b00, 1, 1);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    #1 check("arming_8th", current_state, 1);
    cyc(0, 0, 0, 0);
    #1 check("armed_state", current_state, 2);
    check("armed_left", time_left_sec, 60);

    // full countdown to failure
    for (int i = 0; i < 400 && m_st != 4; i++) cyc(0, 2'($urandom), 0, 0);
    cyc(0, 0, 0, 0);
    #1 check("cd_failed", current_state, 4);
    check("cd_left", time_left_sec, 0);
    check("cd_tout", time_out, 1);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    #1 check("restart_idle", current_state, 0);

    // success at 42 s
    cyc(1, 2'b11, 0, 0);
    for (int i = 0; i < 500 && !(m_st == 2 && m_left == 42); i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    repeat (5) cyc(0, 0, 0, 0);
    #1 check("succ_state", current_state, 5);
    check("succ_left", time_left_sec, 42);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    #1 check("succ_idle", current_state, 0);
    check("succ_idle_left", time_left_sec, 0);

    // simultaneous explode and solve
    cyc(1, 2'b10, 0, 0);
    repeat (12) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);
    #1 check("both_det", current_state, 3);
    for (int i = 0; i < 20 && m_st != 4; i++) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);

    // async reset at 100 s left, then 300 s start
    cyc(1, 2'b01, 0, 0);
    for (int i = 0; i < 600 && !(m_st == 2 && m_left == 100); i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    #1 check("pre_rst_left", time_left_sec, 100);
    rst_v = 1'b0;
    cyc(0, 0, 0, 0);
    #1 check("async_state", current_state, 0);
    check("async_left", time_left_sec, 0);
    check("async_tout", time_out, 0);
    check("async_tick", sec_tick, 0);
    rst_v = 1'b1;
    cyc(1, 2'b00, 0, 0);
    repeat (9) cyc(0, 2'b11, 0, 0);
    #1 check("load300", time_left_sec, 300);

    // randomized play
    repeat (2500) begin
      rst_v = ($urandom_range(0, 599) != 0);
      cyc($urandom_range(0, 29) == 0, 2'($urandom),
          $urandom_range(0, 149) == 0, $urandom_range(0, 149) == 0);
    end
    rst_v = 1'b1;
    cyc(0, 0, 0, 0);

    @(posedge clk);
    #3;
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
